// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle datapath and its program loader.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte packer: the first byte of a word ends up in the top byte.
// The first three bytes are held in a shift register. 'word' shows that
// register with the byte currently on byte_in appended, so when 'full' is
// high the byte being shifted in completes 'word' and the loader can
// register it on the same edge.
module word_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    localparam int HOLD_W = WORD_W - 8;

    logic [HOLD_W-1:0]     hold;
    logic [BYTE_CNT_W-1:0] cnt;

    // Shift in accepted bytes MSB-first and count them modulo the word size.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n || clr) begin
            hold <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            hold <= {hold[HOLD_W-9:0], byte_in};
            cnt  <= cnt + BYTE_CNT_W'(1);
        end
    end

    assign word = {hold, byte_in};
    assign full = (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into instruction memory as big-endian words
// starting at address 0, and holds the CPU until the image is written.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    loader_state_t     state;
    logic [CNT_W-1:0]  index;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  index_inc;
    logic [WORD_W-1:0] packed_word;
    logic              word_full;
    logic              take_byte;
    logic              start_ok;

    // byte_ready is a register that is only high in RECV, so a handshake
    // can only happen while collecting bytes.
    assign take_byte = byte_valid && byte_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign index_inc = index + CNT_W'(1);

    word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .shift_en (take_byte),
        .byte_in  (byte_in),
        .word     (packed_word),
        .full     (word_full)
    );

    // Loader FSM with all outputs registered; mem_addr/mem_wdata only
    // change when a write is launched, so they hold outside WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            count      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        index <= '0;
                        count <= word_count;
                        if (word_count == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else if (32'(word_count) > 32'(DEPTH)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else begin
                            state      <= RECV;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (take_byte && word_full) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= 32'({index, 2'b00});
                        mem_wdata  <= packed_word;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    index  <= index_inc;
                    if (index_inc == count) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= err;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams, a scoreboard
// of expected memory writes, and a negedge monitor that retires them.
module tb_imem_loader;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_hold;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          start_cyc;
    logic [7:0]  stim[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            check("write_byte_ready_low", byte_ready, 1'b0);
            if (exp_addr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", mem_addr, mem_wdata);
            end else begin
                check("write_addr", mem_addr, exp_addr.pop_front());
                check("write_data", mem_wdata, exp_data.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the k-th group of four bytes becomes word k at byte address 4k.
    task automatic push_expected(input int nbytes);
        for (int w = 0; w < nbytes / 4; w++) begin
            exp_addr.push_back(32'(w * 4));
            exp_data.push_back({stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]});
        end
    endtask

    task automatic fill_random(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    // Pulse start for one cycle; afterwards word_count is scrambled since it
    // must only be sampled on the start cycle.
    task automatic do_start(input logic [CNT_W-1:0] n);
        start      = 1'b1;
        word_count = n;
        step();
        start_cyc  = cyc;
        start      = 1'b0;
        word_count = CNT_W'($urandom);
    endtask

    // mode 0: constant valid, 1: valid every other cycle, 2: random valid.
    // start_at >= 0 pulses start (word_count=1) on that cycle of the stream.
    task automatic feed(input string name, input int nbytes, input int mode, input int start_at);
        int idx  = 0;
        int iter = 0;
        bit v;
        bit acc;
        while (idx < nbytes && iter < 20 * nbytes + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (iter % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid = v;
            byte_in    = v ? stim[idx] : 8'($urandom);
            if (iter == start_at) begin
                start      = 1'b1;
                word_count = CNT_W'(1);
            end
            @(negedge clk);
            acc = byte_valid && byte_ready;
            step();
            start = 1'b0;
            if (acc) idx++;
            iter++;
        end
        byte_valid = 1'b0;
        check({name, "_bytes_taken"}, idx, nbytes);
    endtask

    // exp_lat is in clock edges after the edge that sampled start; -1 skips it.
    task automatic wait_done(input string name, input int exp_lat, input bit exp_err);
        bit seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            if (exp_lat >= 0) check({name, "_latency"}, cyc - start_cyc, exp_lat);
            check({name, "_busy_low"}, busy, 1'b0);
            check({name, "_err"}, err, exp_err);
            check({name, "_cpu_hold"}, cpu_hold, exp_err);
        end
        check({name, "_writes_left"}, exp_addr.size(), 0);
        step();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_byte_ready"}, byte_ready, 1'b0);
        check({name, "_mem_we"}, mem_we, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_err"}, err, 1'b0);
        check({name, "_cpu_hold"}, cpu_hold, 1'b1);
        check({name, "_mem_addr"}, mem_addr, 32'h0);
        check({name, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    logic [7:0] prog2 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        int n;
        int mode;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Directed two-word program, constant valid.
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(prog2[i]);
        exp_addr.push_back(32'h0); exp_data.push_back(32'h2008_0005);
        exp_addr.push_back(32'h4); exp_data.push_back(32'h0000_0000);
        do_start(CNT_W'(2));
        check("load2_busy", busy, 1'b1);
        feed("load2", 8, 0, -1);
        wait_done("load2", 10, 1'b0);

        // Same program with valid toggling every other cycle.
        exp_addr.push_back(32'h0); exp_data.push_back(32'h2008_0005);
        exp_addr.push_back(32'h4); exp_data.push_back(32'h0000_0000);
        do_start(CNT_W'(2));
        feed("toggle2", 8, 1, -1);
        wait_done("toggle2", -1, 1'b0);

        // Zero-length load: done immediately, no writes, bytes not consumed.
        do_start(CNT_W'(0));
        check("zero_done", done, 1'b1);
        check("zero_err", err, 1'b0);
        check("zero_cpu_hold", cpu_hold, 1'b0);
        check("zero_busy", busy, 1'b0);
        byte_valid = 1'b1;
        repeat (3) step();
        check("zero_byte_ready", byte_ready, 1'b0);
        byte_valid = 1'b0;

        // Oversized load request.
        do_start(CNT_W'(DEPTH + 1));
        check("ovf_done", done, 1'b1);
        check("ovf_err", err, 1'b1);
        check("ovf_cpu_hold", cpu_hold, 1'b1);
        check("ovf_busy", busy, 1'b0);
        byte_valid = 1'b1;
        repeat (3) step();
        byte_valid = 1'b0;
        check("ovf_err_held", err, 1'b1);
        check("ovf_byte_ready", byte_ready, 1'b0);

        // Largest legal load fills the whole memory.
        fill_random(4 * DEPTH);
        push_expected(4 * DEPTH);
        do_start(CNT_W'(DEPTH));
        check("full_err_cleared", err, 1'b0);
        feed("full", 4 * DEPTH, 0, -1);
        wait_done("full", 5 * DEPTH, 1'b0);

        // Reset in the middle of word 1 of a 3-word load; word 0 stays written.
        fill_random(12);
        push_expected(6);
        do_start(CNT_W'(3));
        feed("abort", 6, 0, -1);
        rst_n = 1'b0;
        step();
        check_reset_values("midreset");
        check("midreset_word0_written", exp_addr.size(), 0);
        rst_n = 1'b1;
        step();
        fill_random(12);
        push_expected(12);
        do_start(CNT_W'(3));
        feed("restart", 12, 2, -1);
        wait_done("restart", -1, 1'b0);

        // start pulsed during RECV is ignored; then reload from DONE.
        fill_random(12);
        push_expected(12);
        do_start(CNT_W'(3));
        feed("ignore_start", 12, 0, 2);
        wait_done("ignore_start", 15, 1'b0);
        fill_random(8);
        push_expected(8);
        do_start(CNT_W'(2));
        check("reload_done_low", done, 1'b0);
        check("reload_cpu_hold", cpu_hold, 1'b1);
        feed("reload", 8, 1, -1);
        wait_done("reload", -1, 1'b0);

        // Random loads.
        for (int k = 0; k < 6; k++) begin
            n    = $urandom_range(1, DEPTH);
            mode = $urandom_range(0, 2);
            fill_random(4 * n);
            push_expected(4 * n);
            do_start(CNT_W'(n));
            feed("rand", 4 * n, mode, -1);
            wait_done("rand", (mode == 0) ? 5 * n : -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
